// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - instruction fetch stage: sequential PC, 1-cycle memory, FIFO to decode
module ifu_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          IM_ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 im_en,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_rdata,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  input  logic                 out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             drop_q, drop_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      mem_q [DEPTH];

  logic [CNT_W:0]   used;
  logic [31:0]      pc_off;
  logic             push;
  logic             pop;
  logic             unused_bits;

  // Credit check counts the read in flight so a return always has a free slot.
  assign used      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign im_en     = !reset && !redirect_valid && (used < DEPTH_C);
  assign pc_off    = fetch_pc_q - RESET_PC;
  assign im_addr   = pc_off[IM_ADDR_W+1:2];

  assign out_valid = (count_q != '0) && !redirect_valid;
  assign out_pc    = mem_q[head_q][63:32];
  assign out_instr = mem_q[head_q][31:0];

  assign push = inflight_q && !drop_q && !redirect_valid;
  assign pop  = out_valid && out_ready;

  assign unused_bits = ^{redirect_pc[1:0], pc_off[1:0], pc_off[31:IM_ADDR_W+2]};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    drop_d     = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = inflight_q;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = im_en;
      if (im_en) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {req_pc_q, im_rdata};
  end

endmodule
